// File: rtl/brc_sliced.sv
`default_nettype none
// ============================================================================
//  Module   : brc_sliced
//  Brief    : Multi-cycle branch comparator. Compares two operands one slice
//             per cycle, MSB slice first, with early exit on the first
//             differing slice. Produces less-than (signed or unsigned) and
//             equality flags behind a valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module brc_sliced #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_rs1_data,
  input  logic [WIDTH-1:0] i_rs2_data,
  input  logic             i_br_un,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_br_less,
  output logic             o_br_equal
);

  localparam int NSL = WIDTH / SLICE;
  localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;

  localparam logic [IW-1:0]    c_idx_top   = IW'(NSL - 1);
  localparam logic [WIDTH-1:0] c_sign_mask = {1'b1, {(WIDTH-1){1'b0}}};

  // Reject geometries that cannot be sliced evenly.
  generate
    if ((SLICE < 1) || (WIDTH < 2) || ((WIDTH % SLICE) != 0)) begin : g_bad_params
      $error("brc_sliced: WIDTH must be >=2 and a multiple of SLICE (SLICE>=1)");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IW-1:0]    r_idx;
  logic             r_less;
  logic             r_equal;
  logic [SLICE-1:0] w_sa;
  logic [SLICE-1:0] w_sb;
  logic             w_diff;
  logic             w_lt;
  logic             w_accept;
  logic             w_last;

  // Select the slice currently under comparison.
  always_comb begin
    w_sa = '0;
    w_sb = '0;
    for (int i = 0; i < NSL; i++) begin
      if (r_idx == IW'(i)) begin
        w_sa = r_a[i*SLICE +: SLICE];
        w_sb = r_b[i*SLICE +: SLICE];
      end
    end
  end

  assign w_diff   = (w_sa != w_sb);
  assign w_lt     = (w_sa < w_sb);
  assign w_last   = (r_idx == '0);
  assign w_accept = i_valid && (r_state == IDLE) && !i_flush;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    if (i_flush) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (i_valid) w_state_nxt = CMP;
        CMP:     if (w_diff || w_last) w_state_nxt = DONE;
        DONE:    if (i_ready) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Operand capture, slice walk and result registers. Signed mode is folded
  // into the operands at accept by flipping the sign bit of both, which turns
  // a signed compare into an unsigned one and leaves equality untouched.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= c_idx_top;
      r_less  <= 1'b0;
      r_equal <= 1'b0;
    end else if (i_flush) begin
      r_idx   <= c_idx_top;
      r_less  <= 1'b0;
      r_equal <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a     <= i_rs1_data ^ (i_br_un ? '0 : c_sign_mask);
            r_b     <= i_rs2_data ^ (i_br_un ? '0 : c_sign_mask);
            r_idx   <= c_idx_top;
            r_less  <= 1'b0;
            r_equal <= 1'b0;
          end
        end
        CMP: begin
          if (w_diff) begin
            r_less  <= w_lt;
            r_equal <= 1'b0;
          end else if (w_last) begin
            r_less  <= 1'b0;
            r_equal <= 1'b1;
          end else begin
            r_idx <= r_idx - IW'(1);
          end
        end
        DONE: begin
          if (i_ready) begin
            r_idx   <= c_idx_top;
            r_less  <= 1'b0;
            r_equal <= 1'b0;
          end
        end
        default: begin
          r_idx   <= c_idx_top;
          r_less  <= 1'b0;
          r_equal <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready    = (r_state == IDLE);
  assign o_valid    = (r_state == DONE);
  assign o_br_less  = r_less;
  assign o_br_equal = r_equal;

endmodule
`default_nettype wire

// File: tb/tb_brc_sliced.sv
`default_nettype none
// ============================================================================
//  Module   : tb_brc_sliced
//  Brief    : Scoreboard bench for brc_sliced (WIDTH=32, SLICE=8). Expected
//             results come from a flag/latency model built on plain integer
//             compares; a monitor pops and checks each result as it appears.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_brc_sliced;

  localparam int WIDTH = 32;
  localparam int SLICE = 8;
  localparam int NSL   = WIDTH / SLICE;

  typedef struct packed {
    logic       less;
    logic       eq;
    logic [7:0] lat;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] rs1;
  logic [WIDTH-1:0] rs2;
  logic             br_un;
  logic             i_flush;
  logic             o_valid;
  logic             i_ready;
  logic             o_br_less;
  logic             o_br_equal;

  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  logic prev_v      = 1'b0;
  exp_t exp_q[$];
  int   acc_q[$];

  brc_sliced #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_rs1_data (rs1),
    .i_rs2_data (rs2),
    .i_br_un    (br_un),
    .i_flush    (i_flush),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_br_less  (o_br_less),
    .o_br_equal (o_br_equal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle count used to measure accept-to-valid latency.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, expv, $time);
    end
  endtask

  // Reference: flags from integer compares; latency is the number of slices
  // down to and including the most significant differing one.
  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic un);
    exp_t e;
    e.less = un ? (a < b) : ($signed(a) < $signed(b));
    e.eq   = (a == b);
    e.lat  = 8'(NSL);
    for (int s = 0; s < NSL; s++) begin
      if (a[s*SLICE +: SLICE] != b[s*SLICE +: SLICE]) e.lat = 8'(NSL - s);
    end
    return e;
  endfunction

  // Monitor: record accepts, check each result on its first valid cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      acc_q.delete();
      prev_v = 1'b0;
    end else begin
      chk("less_equal_exclusive", {31'd0, o_br_less & o_br_equal}, 32'd0);
      if (!o_valid) chk("flags_zero_when_invalid", {30'd0, o_br_less, o_br_equal}, 32'd0);
      if (o_valid && !prev_v) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_valid: got o_valid=1 expected no pending result (t=%0t)", $time);
        end else begin
          exp_t e;
          int   t;
          e = exp_q.pop_front();
          t = acc_q.pop_front();
          chk("result_less",    {31'd0, o_br_less},  {31'd0, e.less});
          chk("result_equal",   {31'd0, o_br_equal}, {31'd0, e.eq});
          chk("result_latency", 32'(cyc - t),        {24'd0, e.lat});
        end
      end
      if (i_flush) acc_q.delete();
      else if (i_valid && o_ready) acc_q.push_back(cyc + 1);
      prev_v = o_valid;
    end
  end

  // Issue one compare, wait for the result, stall `stall` cycles, consume.
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic un, input int stall);
    logic l0, q0;
    exp_q.push_back(model(a, b, un));
    chk("ready_before_issue", {31'd0, o_ready}, 32'd1);
    i_valid = 1'b1; rs1 = a; rs2 = b; br_un = un;
    @(posedge clk); #1;
    i_valid = 1'b0; rs1 = $urandom; rs2 = $urandom; br_un = 1'($urandom);
    for (int t = 0; t < NSL + 2 && !o_valid; t++) begin
      @(posedge clk); #1;
    end
    if (!o_valid) begin
      vectors++;
      miscompares++;
      $display("FAIL result_timeout: got no o_valid expected within %0d cycles", NSL + 2);
      void'(exp_q.pop_back());
      i_flush = 1'b1;
      @(posedge clk); #1;
      i_flush = 1'b0;
    end else begin
      l0 = o_br_less;
      q0 = o_br_equal;
      for (int s = 0; s < stall; s++) begin
        i_valid = 1'b1; rs1 = $urandom; rs2 = $urandom;
        @(posedge clk); #1;
        chk("stall_valid", {31'd0, o_valid},    32'd1);
        chk("stall_less",  {31'd0, o_br_less},  {31'd0, l0});
        chk("stall_equal", {31'd0, o_br_equal}, {31'd0, q0});
        chk("stall_ready", {31'd0, o_ready},    32'd0);
      end
      i_valid = 1'b0; i_ready = 1'b1;
      @(posedge clk); #1;
      i_ready = 1'b0;
      chk("post_consume_valid", {31'd0, o_valid}, 32'd0);
      chk("post_consume_ready", {31'd0, o_ready}, 32'd1);
    end
  endtask

  // Main stimulus sequence.
  initial begin
    logic [WIDTH-1:0] a, b;
    int               sel;
    rst_n = 1'b0; i_valid = 1'b0; rs1 = '0; rs2 = '0; br_un = 1'b0;
    i_flush = 1'b0; i_ready = 1'b0;
    #12;
    chk("reset_ready", {31'd0, o_ready},    32'd1);
    chk("reset_valid", {31'd0, o_valid},    32'd0);
    chk("reset_less",  {31'd0, o_br_less},  32'd0);
    chk("reset_equal", {31'd0, o_br_equal}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(32'h0000_0005, 32'h0000_0005, 1'b1, 0);
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 0);
    do_op(32'h1234_5600, 32'h1234_5700, 1'b1, 0);
    do_op(32'h1234_5700, 32'h1234_5600, 1'b1, 0);
    do_op(32'hA5A5_0001, 32'hA5A5_0002, 1'b0, 3);

    // Flush during the second CMP cycle of an equal compare.
    i_valid = 1'b1; rs1 = 32'h0BAD_F00D; rs2 = 32'h0BAD_F00D; br_un = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk); #1;
    i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
    chk("flush_cmp_ready", {31'd0, o_ready}, 32'd1);
    chk("flush_cmp_valid", {31'd0, o_valid}, 32'd0);
    repeat (NSL + 2) @(posedge clk);
    #1;
    do_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 0);

    // Flush together with a request in IDLE must not accept.
    i_valid = 1'b1; i_flush = 1'b1; rs1 = 32'd1; rs2 = 32'd2;
    @(posedge clk); #1;
    i_valid = 1'b0; i_flush = 1'b0;
    chk("flush_idle_ready", {31'd0, o_ready}, 32'd1);
    repeat (NSL + 2) @(posedge clk);
    #1;

    // Flush while a result is waiting.
    exp_q.push_back(model(32'h0000_0010, 32'h0000_0020, 1'b1));
    i_valid = 1'b1; rs1 = 32'h0000_0010; rs2 = 32'h0000_0020; br_un = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    for (int t = 0; t < NSL + 2 && !o_valid; t++) begin
      @(posedge clk); #1;
    end
    chk("flush_done_pre_valid", {31'd0, o_valid}, 32'd1);
    i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
    chk("flush_done_valid", {31'd0, o_valid}, 32'd0);
    chk("flush_done_ready", {31'd0, o_ready}, 32'd1);

    // Asynchronous reset during CMP.
    i_valid = 1'b1; rs1 = 32'h0000_0005; rs2 = 32'h0000_0005; br_un = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_cmp_ready", {31'd0, o_ready}, 32'd1);
    chk("async_rst_cmp_valid", {31'd0, o_valid}, 32'd0);
    chk("async_rst_cmp_flags", {30'd0, o_br_less, o_br_equal}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(32'h0000_0005, 32'h0000_0005, 1'b1, 0);

    // Asynchronous reset while an equal result is on the outputs.
    exp_q.push_back(model(32'h0000_0005, 32'h0000_0005, 1'b1));
    i_valid = 1'b1; rs1 = 32'h0000_0005; rs2 = 32'h0000_0005; br_un = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    for (int t = 0; t < NSL + 2 && !o_valid; t++) begin
      @(posedge clk); #1;
    end
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_done_valid", {31'd0, o_valid}, 32'd0);
    chk("async_rst_done_flags", {30'd0, o_br_less, o_br_equal}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(32'h0000_0005, 32'h0000_0005, 1'b1, 0);

    // Randomized compares biased towards every possible exit slice.
    for (int n = 0; n < 150; n++) begin
      a   = $urandom;
      sel = $urandom_range(0, NSL + 1);
      if (sel == NSL) begin
        b = a;
      end else if (sel > NSL) begin
        b = $urandom;
      end else begin
        b = a ^ ((WIDTH'($urandom & ((1 << SLICE) - 1)) | WIDTH'(1)) << (sel * SLICE));
        b = b ^ (WIDTH'($urandom) & ((WIDTH'(1) << (sel * SLICE)) - WIDTH'(1)));
      end
      do_op(a, b, 1'($urandom), $urandom_range(0, 3));
    end

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
